// File: rtl/tia_horizontal_sequencer.sv
// Horizontal timebase: divide-by-4 slot phases, slot counter with RSYNC reload
// and registered per-slot line strobes.
module tia_horizontal_sequencer #(
  parameter int LINE_COUNTS = 57,
  parameter int SHB_POS     = 0,
  parameter int SHS_POS     = 4,
  parameter int RHS_POS     = 8,
  parameter int RCB_POS     = 12,
  parameter int RHB_POS     = 16,
  parameter int LRHB_POS    = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rsync,
  output logic       hphi1,
  output logic       hphi2,
  output logic       shb,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       lrhb,
  output logic       cnt,
  output logic       rsynd,
  output logic [5:0] hcount,
  output logic       line_start
);
  localparam logic [5:0] LAST = 6'(LINE_COUNTS - 1);

  logic [1:0] p_q, p_d;
  logic [5:0] slot_q, slot_d;
  logic       rpend_q, rpend_d;
  logic [10:0] out_q, out_d;
  logic [5:0] hcount_q;

  always_comb begin
    p_d     = p_q + 2'd1;
    slot_d  = slot_q;
    rpend_d = rpend_q;
    if (p_q == 2'd3) begin
      // A pending or coincident RSYNC wins over the normal wrap/advance.
      if (rpend_q || rsync) begin
        slot_d  = '0;
        rpend_d = 1'b0;
      end else if (slot_q == LAST) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + 6'd1;
      end
    end else if (rsync) begin
      rpend_d = 1'b1;
    end
    out_d = {
      p_d == 2'd0,
      p_d == 2'd2,
      slot_d == 6'(SHB_POS),
      slot_d == 6'(SHS_POS),
      slot_d == 6'(RHS_POS),
      slot_d == 6'(RCB_POS),
      slot_d == 6'(RHB_POS),
      slot_d == 6'(LRHB_POS),
      slot_d == LAST,
      rpend_d,
      (p_d == 2'd0) && (slot_d == 6'd0)
    };
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q      <= 2'd3;
      slot_q   <= LAST;
      rpend_q  <= 1'b0;
      out_q    <= '0;
      hcount_q <= '0;
    end else begin
      p_q      <= p_d;
      slot_q   <= slot_d;
      rpend_q  <= rpend_d;
      out_q    <= out_d;
      hcount_q <= slot_d;
    end
  end

  assign {hphi1, hphi2, shb, shs, rhs, rcb, rhb, lrhb, cnt, rsynd, line_start} = out_q;
  assign hcount = hcount_q;
endmodule
